// File: rtl/mult_share_ctrl.sv
// Round-robin scheduler sharing one sequential 8x8 multiplier between NREQ requesters.
// Optional watchdog (err port, RUN timeout) enabled by defining MSC_WATCHDOG_EN.
module mult_share_ctrl #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*8-1:0]    a_in,
   input  logic [NREQ*8-1:0]    b_in,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      resp_valid,
   output logic [16:0]          resp_prod,
   output logic                 busy,
   output logic                 mul_reset,
   output logic                 mul_start,
   output logic [7:0]           mul_multiplier,
   output logic [7:0]           mul_multiplicand,
   input  logic [16:0]          mul_product,
   input  logic                 mul_done
`ifdef MSC_WATCHDOG_EN
   ,
   output logic                 err
`endif
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      RESP
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     sel_q, sel_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
   logic [16:0]       resp_prod_q, resp_prod_d;
   logic              busy_q, busy_d;
   logic              mul_reset_q, mul_reset_d;
   logic              mul_start_q, mul_start_d;
   logic [7:0]        mul_multiplier_q, mul_multiplier_d;
   logic [7:0]        mul_multiplicand_q, mul_multiplicand_d;

   logic              found;
   logic [IW-1:0]     pick;
   logic [IW:0]       cand_sum;
   logic [IW-1:0]     cand;
   logic [IW-1:0]     ptr_next;

`ifdef MSC_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;
`endif

   // Round-robin search: first requester at or above the pointer, wrapping mod NREQ.
   always_comb begin
      found    = 1'b0;
      pick     = '0;
      cand_sum = '0;
      cand     = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_sum = {1'b0, ptr_q} + (IW+1)'(k);
         if (cand_sum >= (IW+1)'(NREQ)) begin
            cand_sum = cand_sum - (IW+1)'(NREQ);
         end
         cand = cand_sum[IW-1:0];
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign ptr_next = (sel_q == IW'(NREQ - 1)) ? '0 : sel_q + IW'(1);

   always_comb begin
      state_d            = state_q;
      ptr_d              = ptr_q;
      sel_d              = sel_q;
      gnt_d              = '0;
      resp_valid_d       = '0;
      resp_prod_d        = resp_prod_q;
      mul_multiplier_d   = mul_multiplier_q;
      mul_multiplicand_d = mul_multiplicand_q;
`ifdef MSC_WATCHDOG_EN
      cnt_d              = cnt_q;
      err_d              = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d            = LOAD;
               sel_d              = pick;
               gnt_d[pick]        = 1'b1;
               mul_multiplier_d   = a_in[{pick, 3'b000} +: 8];
               mul_multiplicand_d = b_in[{pick, 3'b000} +: 8];
            end
         end
         LOAD: begin
            state_d = RUN;
`ifdef MSC_WATCHDOG_EN
            cnt_d   = '0;
`endif
         end
         RUN: begin
            if (mul_done) begin
               state_d             = RESP;
               resp_prod_d         = mul_product;
               resp_valid_d[sel_q] = 1'b1;
            end
`ifdef MSC_WATCHDOG_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d             = RESP;
               resp_prod_d         = 17'h1FFFF;
               resp_valid_d[sel_q] = 1'b1;
               err_d               = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         RESP: begin
            state_d = IDLE;
            ptr_d   = ptr_next;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Multiplier controls follow the state being entered so they are registered.
      busy_d      = (state_d != IDLE);
      mul_reset_d = (state_d == IDLE) || (state_d == RESP);
      mul_start_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q            <= IDLE;
         ptr_q              <= '0;
         sel_q              <= '0;
         gnt_q              <= '0;
         resp_valid_q       <= '0;
         resp_prod_q        <= '0;
         busy_q             <= 1'b0;
         mul_reset_q        <= 1'b1;
         mul_start_q        <= 1'b0;
         mul_multiplier_q   <= '0;
         mul_multiplicand_q <= '0;
      end else begin
         state_q            <= state_d;
         ptr_q              <= ptr_d;
         sel_q              <= sel_d;
         gnt_q              <= gnt_d;
         resp_valid_q       <= resp_valid_d;
         resp_prod_q        <= resp_prod_d;
         busy_q             <= busy_d;
         mul_reset_q        <= mul_reset_d;
         mul_start_q        <= mul_start_d;
         mul_multiplier_q   <= mul_multiplier_d;
         mul_multiplicand_q <= mul_multiplicand_d;
      end
   end

`ifdef MSC_WATCHDOG_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`endif

   assign gnt              = gnt_q;
   assign resp_valid       = resp_valid_q;
   assign resp_prod        = resp_prod_q;
   assign busy             = busy_q;
   assign mul_reset        = mul_reset_q;
   assign mul_start        = mul_start_q;
   assign mul_multiplier   = mul_multiplier_q;
   assign mul_multiplicand = mul_multiplicand_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl with a behavioural shift-add multiplier attached.
// Round-robin expectations come from a simple pointer model; products from plain a*b.
module tb_mult_share_ctrl;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 64;

   logic                clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req;
   logic [NREQ*8-1:0]   a_in;
   logic [NREQ*8-1:0]   b_in;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     resp_valid;
   logic [16:0]         resp_prod;
   logic                busy;
   logic                mul_reset;
   logic                mul_start;
   logic [7:0]          mul_multiplier;
   logic [7:0]          mul_multiplicand;
   logic [16:0]         m_prod = '0;
   logic                m_done = 1'b0;
`ifdef MSC_WATCHDOG_EN
   logic                err;
`endif

   int checks = 0;
   int errors = 0;
   int ptr_m  = 0;
   int mlat   = 8;
   int m_cnt  = 0;
   bit stuck  = 1'b0;

   always #5 clk = ~clk;

   mult_share_ctrl #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk              (clk),
      .reset            (reset),
      .req              (req),
      .a_in             (a_in),
      .b_in             (b_in),
      .gnt              (gnt),
      .resp_valid       (resp_valid),
      .resp_prod        (resp_prod),
      .busy             (busy),
      .mul_reset        (mul_reset),
      .mul_start        (mul_start),
      .mul_multiplier   (mul_multiplier),
      .mul_multiplicand (mul_multiplicand),
      .mul_product      (m_prod),
      .mul_done         (m_done)
`ifdef MSC_WATCHDOG_EN
      ,
      .err              (err)
`endif
   );

   // Attached multiplier: done rises mlat cycles after start, held until mul_reset.
   always @(posedge clk) begin
      if (mul_reset) begin
         m_done <= 1'b0;
         m_cnt  <= 0;
      end else if (mul_start && !m_done && !stuck) begin
         if (m_cnt >= mlat) begin
            m_done <= 1'b1;
            m_prod <= 17'(mul_multiplier) * 17'(mul_multiplicand);
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         checks++;
         if ((gnt != '0) && (resp_valid != '0)) begin
            errors++;
            $display("[TB] FAIL gnt_resp_overlap: gnt=%b resp_valid=%b, required not both", gnt, resp_valid);
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
      a_in[8*i +: 8] = a;
      b_in[8*i +: 8] = b;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      ptr_m = 0;
   endtask

   task automatic wait_gnt(output logic [NREQ-1:0] g);
      bit hit = 1'b0;
      g = '0;
      for (int i = 0; i < 60 && !hit; i++) begin
         tick();
         if (gnt != '0) begin
            g   = gnt;
            hit = 1'b1;
         end
      end
   endtask

   task automatic wait_resp(output logic [NREQ-1:0] rv, output logic [16:0] prod);
      bit hit = 1'b0;
      rv   = '0;
      prod = 'x;
      for (int i = 0; i < 120 && !hit; i++) begin
         tick();
         if (resp_valid != '0) begin
            rv   = resp_valid;
            prod = resp_prod;
            hit  = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req   = '0;
      a_in  = '0;
      b_in  = '0;
      tick();
      tick();
      checks++;
      if ({gnt, resp_valid, busy, mul_start, mul_reset} !== {4'b0, 4'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b, required %b",
                  {gnt, resp_valid, busy, mul_start, mul_reset}, {4'b0, 4'b0, 1'b0, 1'b0, 1'b1});
      end
      checks++;
      if ({resp_prod, mul_multiplier, mul_multiplicand} !== 33'd0) begin
         errors++;
         $display("[TB] FAIL reset_data: got %h, required 0", {resp_prod, mul_multiplier, mul_multiplicand});
      end
`ifdef MSC_WATCHDOG_EN
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_err: got %b, required 0", err);
      end
`endif
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [NREQ-1:0] rv;
      logic [16:0]     prod;
      set_ops(0, 8'd250, 8'd255);
      req = 4'b0001;
      tick();
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL single_gnt: got %b, required 0001", gnt);
      end
      checks++;
      if ({mul_multiplier, mul_multiplicand, mul_reset, mul_start, busy} !== {8'd250, 8'd255, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL single_load: got a=%0d b=%0d rst=%b start=%b busy=%b, required 250 255 0 0 1",
                  mul_multiplier, mul_multiplicand, mul_reset, mul_start, busy);
      end
      req = '0;
      wait_resp(rv, prod);
      checks++;
      if (rv !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL single_resp_valid: got %b, required 0001", rv);
      end
      checks++;
      if (prod !== 17'd63750) begin
         errors++;
         $display("[TB] FAIL single_prod: got %0d, required 63750", prod);
      end
      tick();
      checks++;
      if ({busy, resp_valid} !== {1'b0, 4'b0}) begin
         errors++;
         $display("[TB] FAIL single_idle: got busy=%b resp_valid=%b, required 0 0000", busy, resp_valid);
      end
      ptr_m = 1;
   endtask

   task automatic test_all_four();
      logic [NREQ-1:0] g, rv;
      logic [16:0]     prod;
      int              exp_p[4] = '{182, 816, 7448, 10302};
      pulse_reset();
      set_ops(0, 8'd14, 8'd13);
      set_ops(1, 8'd24, 8'd34);
      set_ops(2, 8'd76, 8'd98);
      set_ops(3, 8'd101, 8'd102);
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(g);
         checks++;
         if (g !== 4'(1 << k)) begin
            errors++;
            $display("[TB] FAIL all4_gnt%0d: got %b, required %b", k, g, 4'(1 << k));
         end
         req[k] = 1'b0;
         wait_resp(rv, prod);
         checks++;
         if ({rv, prod} !== {4'(1 << k), 17'(exp_p[k])}) begin
            errors++;
            $display("[TB] FAIL all4_resp%0d: got %b/%0d, required %b/%0d", k, rv, prod, 4'(1 << k), exp_p[k]);
         end
      end
      ptr_m = 0;
   endtask

   task automatic test_fairness();
      logic [NREQ-1:0] g, rv;
      logic [16:0]     prod;
      set_ops(2, 8'd5, 8'd6);
      req = 4'b0100;
      wait_gnt(g);
      req = '0;
      wait_resp(rv, prod);
      checks++;
      if ({g, rv, prod} !== {4'b0100, 4'b0100, 17'd30}) begin
         errors++;
         $display("[TB] FAIL fair_first: got %b/%b/%0d, required 0100/0100/30", g, rv, prod);
      end
      set_ops(0, 8'd11, 8'd12);
      set_ops(3, 8'd13, 8'd14);
      req = 4'b1001;
      wait_gnt(g);
      checks++;
      if (g !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL fair_gnt3: got %b, required 1000", g);
      end
      req[3] = 1'b0;
      wait_resp(rv, prod);
      checks++;
      if ({rv, prod} !== {4'b1000, 17'd182}) begin
         errors++;
         $display("[TB] FAIL fair_resp3: got %b/%0d, required 1000/182", rv, prod);
      end
      wait_gnt(g);
      checks++;
      if (g !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL fair_gnt0: got %b, required 0001", g);
      end
      req = '0;
      wait_resp(rv, prod);
      checks++;
      if ({rv, prod} !== {4'b0001, 17'd132}) begin
         errors++;
         $display("[TB] FAIL fair_resp0: got %b/%0d, required 0001/132", rv, prod);
      end
      ptr_m = 1;
   endtask

   task automatic test_reset_midrun();
      logic [NREQ-1:0] g, rv;
      logic [16:0]     prod;
      bit              seen = 1'b0;
      bit              saw_rv = 1'b0;
      mlat = 8;
      set_ops(2, 8'd9, 8'd9);
      req = 4'b0100;
      wait_gnt(g);
      req = '0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (mul_start === 1'b1) seen = 1'b1;
      end
      repeat (5) tick();
      reset = 1'b0;
      #1;
      checks++;
      if ({seen, gnt, resp_valid, busy, mul_start, mul_reset} !== {1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL midrun_reset_ctrl: got %b, required %b",
                  {seen, gnt, resp_valid, busy, mul_start, mul_reset}, {1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1});
      end
      checks++;
      if ({resp_prod, mul_multiplier, mul_multiplicand} !== 33'd0) begin
         errors++;
         $display("[TB] FAIL midrun_reset_data: got %h, required 0", {resp_prod, mul_multiplier, mul_multiplicand});
      end
      repeat (3) begin
         tick();
         if (resp_valid != '0) saw_rv = 1'b1;
      end
      reset = 1'b1;
      ptr_m = 0;
      repeat (12) begin
         tick();
         if (resp_valid != '0) saw_rv = 1'b1;
      end
      checks++;
      if (saw_rv !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrun_dropped: got resp_valid pulse, required none");
      end
      set_ops(1, 8'd3, 8'd7);
      req = 4'b0010;
      wait_gnt(g);
      req = '0;
      wait_resp(rv, prod);
      checks++;
      if ({g, rv, prod} !== {4'b0010, 4'b0010, 17'd21}) begin
         errors++;
         $display("[TB] FAIL midrun_after: got %b/%b/%0d, required 0010/0010/21", g, rv, prod);
      end
      ptr_m = 2;
   endtask

   task automatic test_zero_repeat();
      logic [NREQ-1:0] g, rv;
      logic [16:0]     prod;
      set_ops(1, 8'd0, 8'd200);
      req = 4'b0010;
      wait_gnt(g);
      wait_resp(rv, prod);
      checks++;
      if ({g, rv, prod} !== {4'b0010, 4'b0010, 17'd0}) begin
         errors++;
         $display("[TB] FAIL zero_job: got %b/%b/%0d, required 0010/0010/0", g, rv, prod);
      end
      tick();
      checks++;
      if ({gnt, busy} !== {4'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL repeat_idle_gap: got gnt=%b busy=%b, required 0000 0", gnt, busy);
      end
      tick();
      checks++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL repeat_regrant: got %b, required 0010", gnt);
      end
      req = '0;
      wait_resp(rv, prod);
      checks++;
      if ({rv, prod} !== {4'b0010, 17'd0}) begin
         errors++;
         $display("[TB] FAIL repeat_resp: got %b/%0d, required 0010/0", rv, prod);
      end
      ptr_m = 2;
   endtask

   task automatic test_random();
      logic [NREQ-1:0] g, rv, expg, fresh;
      logic [16:0]     prod;
      int              opa[NREQ];
      int              opb[NREQ];
      int              w;
      for (int j = 0; j < 30; j++) begin
         if (req == '0) fresh = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         else           fresh = NREQ'($urandom) & ~req;
         for (int i = 0; i < NREQ; i++) begin
            if (fresh[i]) begin
               opa[i] = int'($urandom_range(0, 255));
               opb[i] = int'($urandom_range(0, 255));
               set_ops(i, 8'(opa[i]), 8'(opb[i]));
            end
         end
         req = req | fresh;
         w = -1;
         for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && req[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
         end
         expg    = '0;
         expg[w] = 1'b1;
         mlat    = int'($urandom_range(1, 12));
         wait_gnt(g);
         checks++;
         if (g !== expg) begin
            errors++;
            $display("[TB] FAIL rand_gnt[%0d]: got %b, required %b", j, g, expg);
         end
         req[w] = 1'b0;
         if ($urandom_range(0, 3) == 0) req = req & NREQ'($urandom);
         wait_resp(rv, prod);
         checks++;
         if (rv !== expg) begin
            errors++;
            $display("[TB] FAIL rand_valid[%0d]: got %b, required %b", j, rv, expg);
         end
         checks++;
         if (prod !== 17'(opa[w] * opb[w])) begin
            errors++;
            $display("[TB] FAIL rand_prod[%0d]: got %0d, required %0d", j, prod, opa[w] * opb[w]);
         end
         ptr_m = (w + 1) % NREQ;
      end
      req  = '0;
      mlat = 8;
      tick();
      tick();
   endtask

   task automatic test_stuck();
      logic [NREQ-1:0] g;
      bit              seen = 1'b0;
      bit              saw_rv = 1'b0;
      int              cyc = 0;
      stuck = 1'b1;
      set_ops(3, 8'd1, 8'd1);
      req = 4'b1000;
      wait_gnt(g);
      req = '0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (mul_start === 1'b1) seen = 1'b1;
      end
`ifdef MSC_WATCHDOG_EN
      for (int i = 1; i <= 200 && !saw_rv; i++) begin
         tick();
         if (resp_valid != '0) begin
            saw_rv = 1'b1;
            cyc    = i;
            checks++;
            if ({resp_valid, resp_prod, err} !== {4'b1000, 17'h1FFFF, 1'b1}) begin
               errors++;
               $display("[TB] FAIL wdog_resp: got %b/%h/%b, required 1000/1ffff/1", resp_valid, resp_prod, err);
            end
         end
      end
      checks++;
      if (cyc !== TIMEOUT) begin
         errors++;
         $display("[TB] FAIL wdog_latency: got %0d cycles, required %0d", cyc, TIMEOUT);
      end
      tick();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wdog_err_pulse: got %b, required 0", err);
      end
`else
      repeat (150) begin
         tick();
         if (resp_valid != '0) saw_rv = 1'b1;
      end
      checks++;
      if ({seen, busy, mul_start, saw_rv} !== 4'b1110) begin
         errors++;
         $display("[TB] FAIL stuck_wait: got seen/busy/start/resp=%b, required 1110", {seen, busy, mul_start, saw_rv});
      end
      checks++;
      if (cyc !== 0) begin
         errors++;
         $display("[TB] FAIL stuck_count: got %0d, required 0", cyc);
      end
`endif
      stuck = 1'b0;
      pulse_reset();
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_fairness();
      test_reset_midrun();
      test_zero_repeat();
      test_random();
      test_stuck();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Round-robin scheduler that shares one 8x8 sequential shift-add multiplier (start/done handshake, 17-bit product) between NREQ requesters.
- Arbitrates requests, latches the winner's operands, and sequences the multiplier: park in reset, load, start, wait for done.
- Returns the product to the winning requester.
- Sits between client blocks and the single multiplier instance.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 64, watchdog limit in cycles (used only with MSC_WATCHDOG_EN)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; low forces the reset state immediately
req  in  NREQ  per-requester request, level, held until granted
a_in  in  NREQ*8  multiplier operands, requester i at [8i+7:8i]
b_in  in  NREQ*8  multiplicand operands, same packing
gnt  out  NREQ  one-hot, one-cycle pulse; operands latched this cycle
resp_valid  out  NREQ  one-hot, one-cycle pulse; resp_prod valid
resp_prod  out  17  product of the last completed job
busy  out  1  high in every state except IDLE
mul_reset  out  1  active-high reset to the multiplier
mul_start  out  1  start to the multiplier
mul_multiplier  out  8  latched operand a
mul_multiplicand  out  8  latched operand b
mul_product  in  17  multiplier product
mul_done  in  1  multiplier done (level; stays high until the multiplier is reset)

Behaviour:
- All outputs registered.
- Reset values:
  - gnt=0, resp_valid=0, resp_prod=0, busy=0, mul_start=0.
  - mul_multiplier=0, mul_multiplicand=0.
  - mul_reset=1.
  - Round-robin pointer=0, state=IDLE.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - mul_reset=1 (multiplier parked).
  - If any req, select the first set bit searching from pointer upward, wrapping mod NREQ.
  - Next edge: gnt[sel]=1 for that one cycle, latch a_in/b_in slices into mul_multiplier/mul_multiplicand, store sel, go to LOAD.
  - If no req, stay in IDLE.
- LOAD: mul_reset=0, mul_start=0, exactly one cycle -> RUN.
- RUN:
  - mul_start=1.
  - On a cycle where mul_done=1: capture mul_product into resp_prod, drop mul_start, go to RESP.
  - mul_done is ignored in IDLE and LOAD; stale done is cleared by the mul_reset held during IDLE.
- RESP:
  - resp_valid[sel]=1 for one cycle.
  - Pointer=(sel+1) mod NREQ.
  - mul_reset=1, go to IDLE.
- Latency:
  - gnt one cycle after req is seen in IDLE.
  - resp_valid one cycle after the capture edge.
  - Back-to-back jobs: next gnt no earlier than the cycle after resp_valid, giving one IDLE cycle minimum between jobs.
- Fairness: a requester that has just been served has lowest priority next round. With all req high, grant order is 0,1,2,3,0...
- Requester rules:
  - req and operands must be stable until gnt.
  - req sampled high in the IDLE cycle after resp_valid counts as a new job.
  - req dropped before gnt: no grant, no error.
- Product width: 17-bit value passed through unmodified; bit 16 is 0 for valid 8x8 results.
- Reset mid-operation (any state):
  - Immediate return to reset values, including mul_reset=1.
  - Job is dropped with no resp_valid.
  - Pointer returns to 0.
- Simultaneous events: gnt and resp_valid are never both high in the same cycle.

Optional Feature:
- Macro: MSC_WATCHDOG_EN.
- Defined:
  - Adds output err (1 bit, reset 0) and a cycle counter cleared on entry to RUN.
  - If the counter reaches TIMEOUT while in RUN without mul_done, go to RESP with resp_prod=17'h1FFFF and err=1 for that cycle.
  - err is a one-cycle pulse coincident with resp_valid.
- Not defined: no err port, no counter; RUN waits indefinitely for mul_done.

Test Plan:
- Single job, NREQ=4, attached to the team's 8-bit shift-add multiplier: req[0] with a=250, b=255 -> gnt[0] one cycle later; resp_valid[0] with resp_prod=63750; busy low again the cycle after.
- All four req high with (14,13), (24,34), (76,98), (101,102) held -> grants in order 0,1,2,3; resp_prod 182, 816, 7448, 10302, each on the matching resp_valid bit.
- Pointer fairness: job on req[2] completes, then req[0] and req[3] rise together -> gnt[3] first, then gnt[0].
- Reset low in RUN, 5 cycles after mul_start rises -> outputs return to reset values immediately with mul_reset=1 and no resp_valid; a later req[1] with (3,7) -> resp_prod=21.
- Stuck multiplier model (mul_done tied 0):
  - With MSC_WATCHDOG_EN, TIMEOUT=64: 64 cycles after entering RUN -> err and resp_valid pulse with 17'h1FFFF.
  - Without the macro: busy stays high.
- Zero operands and single-requester repeat: req[1] held with (0,200) -> resp_prod=0; req[1] is re-granted after the one mandatory IDLE cycle.
